instruction_fetch: RTL and testbench

Fetch sequencer between the CPU core and `instruction_memory`. It owns the program counter and issues single-cycle reads to the BRAM, which has a fixed 1-cycle latency. Returned words go into a small prefetch buffer and are handed to decode over a valid/ready handshake. A jump redirects the PC, flushes the buffer and discards the one in-flight response.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 47 ++++
 rtl/instruction_fetch_fifo.sv | 62 ++++++
 rtl/instruction_fetch.sv | 117 +++++++++++
 tb/tb_instruction_fetch.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: FSM encoding, default reset PC and bus widths
// common to instruction_fetch and instruction_memory.
package venera_fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 16;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: BRAM read/response and decode handshake.
// o_instr_pc is present only when FETCH_PC_TAG_EN is defined.
interface instruction_fetch_if
  import venera_fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
);

  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_address;
  logic              i_mem_valid;
  logic [DATA_W-1:0] i_mem_dout;
  logic              o_instr_valid;
  logic              i_instr_ready;
  logic [DATA_W-1:0] o_instr;
`ifdef FETCH_PC_TAG_EN
  logic [ADDR_W-1:0] o_instr_pc;
`endif

  modport master (
    output o_mem_rd,
    output o_mem_address,
    input  i_mem_valid,
    input  i_mem_dout,
    output o_instr_valid,
    input  i_instr_ready,
    output o_instr
`ifdef FETCH_PC_TAG_EN
    , output o_instr_pc
`endif
  );

  modport slave (
    input  o_mem_rd,
    input  o_mem_address,
    output i_mem_valid,
    output i_mem_dout,
    input  o_instr_valid,
    output i_instr_ready,
    input  o_instr
`ifdef FETCH_PC_TAG_EN
    , input o_instr_pc
`endif
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Prefetch buffer: shift-register FIFO whose entry 0 is the registered head,
// so the head word and its valid flag come straight from flops.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_WORD = '0,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [CNT_W-1:0] count_nxt;
  logic [IDX_W-1:0] wr_idx;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
    // A same-cycle pop shifts everything down, so the new word lands one lower.
    wr_idx = IDX_W'(pop ? (count - CNT_W'(1)) : count);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= RESET_WORD;
      end
      count      <= '0;
      head_valid <= 1'b0;
    end else if (flush) begin
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          entries[i] <= entries[i+1];
        end
      end
      if (push) begin
        entries[wr_idx] <= din;
      end
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
    end
  end

  assign head = entries[0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: owns the PC, issues 1-cycle BRAM reads against buffer
// credit, and redirects on jump. FETCH_PC_TAG_EN adds o_instr_pc tagging.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | fetch halted; PC may still be redirected
// ST_RUN  | reads issued whenever the buffer has credit
module instruction_fetch
  import venera_fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int DATA_W    = FETCH_DATA_W,
  parameter int BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_addr,
  instruction_fetch_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
`ifdef FETCH_PC_TAG_EN
  localparam int ENTRY_W = DATA_W + ADDR_W;
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = {RESET_PC, {DATA_W{1'b0}}};
`else
  localparam int ENTRY_W = DATA_W;
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = '0;
`endif

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic              stale;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              issue;
  logic              pop;
  logic              push;
  logic              head_valid;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  assign pop       = head_valid & bus.i_instr_ready;
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign credit_ok = occupancy < (CNT_W+1)'(BUF_DEPTH);
  assign issue     = (state == ST_RUN) & ~i_jump & credit_ok;
  assign push      = bus.i_mem_valid & inflight & ~stale;

  assign bus.o_mem_rd      = issue;
  assign bus.o_mem_address = pc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      stale    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_enable)  state <= ST_RUN;
        ST_RUN:  if (!i_enable) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      inflight <= issue;
      stale    <= i_jump & inflight;
      if (i_jump) begin
        pc <= i_jump_addr;
      end else if (issue) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

`ifdef FETCH_PC_TAG_EN
  // Address of the outstanding read, paired with its response on push.
  logic [ADDR_W-1:0] inflight_pc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      inflight_pc <= RESET_PC;
    end else if (issue) begin
      inflight_pc <= pc;
    end
  end

  assign push_data      = {inflight_pc, bus.i_mem_dout};
  assign bus.o_instr    = head[DATA_W-1:0];
  assign bus.o_instr_pc = head[ENTRY_W-1:DATA_W];
`else
  assign push_data   = bus.i_mem_dout;
  assign bus.o_instr = head;
`endif

  assign bus.o_instr_valid = head_valid;

  // Jump flushes the buffer; a response landing in the jump cycle is dropped.
  fetch_fifo #(
    .DEPTH      (BUF_DEPTH),
    .WIDTH      (ENTRY_W),
    .RESET_WORD (RESET_ENTRY)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .push       (push),
    .pop        (pop),
    .flush      (i_jump),
    .din        (push_data),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: BRAM model with mem[k]=A000+k, program-order
// scoreboard, directed timing cases and a randomized phase.
module tb_instruction_fetch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int BUF_DEPTH = 2;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       jump;
  logic [7:0] jaddr;
  logic       spurious_req;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  logic [7:0] q[$];
  logic [7:0] ptr;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instruction_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_jump(jump),
    .i_jump_addr(jaddr), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'hA000 + {8'h00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  // BRAM: 1-cycle latency, optional unsolicited valid pulse.
  initial begin
    logic       rd_l;
    logic [7:0] a_l;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_dout  = '0;
    forever begin
      @(negedge clk);
      rd_l = bus.o_mem_rd & ~rst;
      a_l  = bus.o_mem_address;
      @(posedge clk); #2;
      bus.i_mem_valid = rd_l | spurious_req;
      bus.i_mem_dout  = mem_word(a_l);
      spurious_req    = 1'b0;
    end
  end

  // Scoreboard: reads push the expected address, accepted heads pop it.
  initial begin
    logic [7:0] e;
    ptr = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        ptr = RESET_PC;
      end else begin
        if (bus.o_instr_valid && bus.i_instr_ready && !jump) begin
          n_pops++;
          if (q.size() == 0) begin
            check("pop_unexpected", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("instr_word", bus.o_instr, mem_word(e));
`ifdef FETCH_PC_TAG_EN
            check("instr_pc", bus.o_instr_pc, e);
`endif
          end
        end
        if (jump) begin
          check("jump_no_rd", bus.o_mem_rd, 1'b0);
          q.delete();
          ptr = jaddr;
        end
        if (bus.o_mem_rd) begin
          check("rd_address", bus.o_mem_address, ptr);
          q.push_back(ptr);
          ptr = ptr + 8'd1;
        end
        if (q.size() > BUF_DEPTH) check("occupancy", q.size(), BUF_DEPTH);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nrd, nv, got;
    logic found;
    logic [15:0] held;
    logic [15:0] w [4];
    logic [15:0] wexp [4];
    wexp[0] = 16'hA0FE; wexp[1] = 16'hA0FF; wexp[2] = 16'hA000; wexp[3] = 16'hA001;

    rst = 1'b1; en = 1'b0; jump = 1'b0; jaddr = '0; spurious_req = 1'b0;
    bus.i_instr_ready = 1'b0;

    // Reset values
    repeat (2) at_neg();
    check("rst_rd", bus.o_mem_rd, 1'b0);
    check("rst_addr", bus.o_mem_address, RESET_PC);
    check("rst_valid", bus.o_instr_valid, 1'b0);
    check("rst_instr", bus.o_instr, 16'h0000);
`ifdef FETCH_PC_TAG_EN
    check("rst_pc", bus.o_instr_pc, RESET_PC);
`endif

    // Start-up latency and throughput
    step(); rst = 1'b0; en = 1'b1; bus.i_instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (bus.o_mem_rd) begin found = 1'b1; break; end
    end
    check("first_rd", found, 1'b1);
    at_neg(); check("lat_c1_valid", bus.o_instr_valid, 1'b0);
    at_neg(); check("lat_c2_valid", bus.o_instr_valid, 1'b1);
    check("first_word", bus.o_instr, 16'hA000);
    nv = 0;
    repeat (8) begin at_neg(); nv += int'(bus.o_instr_valid); end
    check("throughput", nv, 8);

    // Back-pressure: stall holds exactly two words, resumes gap-free
    step(); bus.i_instr_ready = 1'b0;
    nrd = 0;
    at_neg(); held = bus.o_instr; nrd += int'(bus.o_mem_rd);
    repeat (9) begin at_neg(); nrd += int'(bus.o_mem_rd); end
    check("stall_rd", nrd, 0);
    check("stall_fill", q.size(), 2);
    check("stall_valid", bus.o_instr_valid, 1'b1);
    check("stall_hold", bus.o_instr, held);
    step(); bus.i_instr_ready = 1'b1;
    nv = 0;
    repeat (6) begin at_neg(); nv += int'(bus.o_instr_valid); end
    check("no_gap", nv, 6);

    // Jump with full buffer and a read in flight
    step(); bus.i_instr_ready = 1'b0;
    repeat (3) step();
    bus.i_instr_ready = 1'b1;
    step(); bus.i_instr_ready = 1'b0; jump = 1'b1; jaddr = 8'h40;
    at_neg(); check("jump_resp_present", bus.i_mem_valid, 1'b1);
    step(); jump = 1'b0; bus.i_instr_ready = 1'b1;
    at_neg(); check("jump_j1_valid", bus.o_instr_valid, 1'b0);
    check("jump_j1_rd", bus.o_mem_rd, 1'b1);
    check("jump_j1_addr", bus.o_mem_address, 8'h40);
    at_neg(); check("jump_j2_valid", bus.o_instr_valid, 1'b0);
    at_neg(); check("jump_j3_valid", bus.o_instr_valid, 1'b1);
    check("jump_word", bus.o_instr, 16'hA040);
`ifdef FETCH_PC_TAG_EN
    check("jump_pc", bus.o_instr_pc, 8'h40);
`endif

    // PC wrap-around
    step(); jump = 1'b1; jaddr = 8'hFE;
    step(); jump = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      at_neg();
      if (bus.o_instr_valid && bus.i_instr_ready) begin w[got] = bus.o_instr; got++; end
    end
    check("wrap_count", got, 4);
    for (int i = 0; i < got; i++) check("wrap_word", w[i], wexp[i]);

    // Reset mid-stream with an unsolicited response right after release
    step(); rst = 1'b1;
    #2;
    check("mrst_rd", bus.o_mem_rd, 1'b0);
    check("mrst_addr", bus.o_mem_address, RESET_PC);
    check("mrst_valid", bus.o_instr_valid, 1'b0);
    check("mrst_instr", bus.o_instr, 16'h0000);
`ifdef FETCH_PC_TAG_EN
    check("mrst_pc", bus.o_instr_pc, RESET_PC);
`endif
    spurious_req = 1'b1;
    step(); rst = 1'b0;
    at_neg();
    at_neg(); check("spurious_ignored", bus.o_instr_valid, 1'b0);
    check("restart_rd", bus.o_mem_rd, 1'b1);
    check("restart_addr", bus.o_mem_address, RESET_PC);
    at_neg(); check("restart_c1_valid", bus.o_instr_valid, 1'b0);
    at_neg(); check("restart_c2_valid", bus.o_instr_valid, 1'b1);
    check("restart_word", bus.o_instr, mem_word(RESET_PC));

    // Enable drop: in-flight word still delivered, no more reads
    repeat (4) step();
    en = 1'b0;
    at_neg();
    nrd = 0;
    repeat (6) begin at_neg(); nrd += int'(bus.o_mem_rd); end
    check("dis_rd", nrd, 0);
    check("dis_drained", q.size(), 0);
    check("dis_valid", bus.o_instr_valid, 1'b0);

    // Jump while idle, then resume at the target
    step(); jump = 1'b1; jaddr = 8'h80;
    step(); jump = 1'b0; en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      if (bus.o_mem_rd) begin found = 1'b1; break; end
    end
    check("idle_jump_rd", found, 1'b1);
    check("idle_jump_addr", bus.o_mem_address, 8'h80);

    // Randomized traffic
    n_pops = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.i_instr_ready = ($urandom_range(0, 3) != 0);
      jump  = ($urandom_range(0, 39) == 0);
      jaddr = 8'($urandom);
      if ($urandom_range(0, 99) == 0) en = ~en;
    end
    step(); jump = 1'b0; en = 1'b1; bus.i_instr_ready = 1'b1;
    repeat (10) step();
    check("random_progress", (n_pops > 100), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
